// File: rtl/warp_xwb.sv
`default_nettype none
// ============================================================================
// Module   : warp_xwb
// Brief    : Scalar writeback arbiter (3 sources -> 2 RF write ports) plus
//            per-register pending scoreboard.
// Revision : 1.0
// ============================================================================
module warp_xwb (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_src0_valid,
    input  logic        i_src1_valid,
    input  logic        i_src2_valid,
    output logic        o_src0_ready,
    output logic        o_src1_ready,
    output logic        o_src2_ready,
    input  logic [4:0]  i_src0_addr,
    input  logic [4:0]  i_src1_addr,
    input  logic [4:0]  i_src2_addr,
    input  logic [63:0] i_src0_data,
    input  logic [63:0] i_src1_data,
    input  logic [63:0] i_src2_data,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_addr,
    output logic [4:0]  o_rd1_addr,
    output logic [4:0]  o_rd2_addr,
    output logic [63:0] o_rd1_wdata,
    output logic [63:0] o_rd2_wdata,
    output logic        o_rd1_wen,
    output logic        o_rd2_wen,
    output logic [31:0] o_pending,
    output logic        o_hazard_err
);

    localparam int unsigned c_NSRC = 3;

    function automatic logic [1:0] f_inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [1:0] f_scan(input logic [1:0] base, input int k);
        logic [2:0] s;
        s = {1'b0, base} + 3'(k);
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    logic [c_NSRC-1:0] w_valid;
    logic [4:0]        w_addr [c_NSRC];
    logic [63:0]       w_data [c_NSRC];

    assign w_valid   = {i_src2_valid, i_src1_valid, i_src0_valid};
    assign w_addr[0] = i_src0_addr;
    assign w_addr[1] = i_src1_addr;
    assign w_addr[2] = i_src2_addr;
    assign w_data[0] = i_src0_data;
    assign w_data[1] = i_src1_data;
    assign w_data[2] = i_src2_data;

    logic [1:0]  rr_q, rr_d;
    logic [4:0]  rd1_addr_q, rd1_addr_d, rd2_addr_q, rd2_addr_d;
    logic [63:0] rd1_data_q, rd1_data_d, rd2_data_q, rd2_data_d;
    logic        rd1_wen_q, rd1_wen_d, rd2_wen_q, rd2_wen_d;
    logic [31:0] pending_q, pending_d;
    logic        hazard_q, hazard_d;

    logic              w_g1_vld, w_g2_vld;
    logic [1:0]        w_g1_idx, w_g2_idx, w_idx;
    logic [c_NSRC-1:0] w_ready;

    // Port 2 skips a candidate that would write the same nonzero register as port 1.
    always_comb begin
        w_g1_vld = 1'b0;
        w_g1_idx = 2'd0;
        w_g2_vld = 1'b0;
        w_g2_idx = 2'd0;
        w_idx    = 2'd0;
        for (int k = 0; k < int'(c_NSRC); k++) begin
            w_idx = f_scan(rr_q, k);
            if (w_valid[w_idx] && !i_rst) begin
                if (!w_g1_vld) begin
                    w_g1_vld = 1'b1;
                    w_g1_idx = w_idx;
                end else if (!w_g2_vld &&
                             !(w_addr[w_idx] == w_addr[w_g1_idx] && w_addr[w_g1_idx] != 5'd0)) begin
                    w_g2_vld = 1'b1;
                    w_g2_idx = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_g1_vld) w_ready[w_g1_idx] = 1'b1;
        if (w_g2_vld) w_ready[w_g2_idx] = 1'b1;

        rr_d = rr_q;
        if (w_g2_vld)      rr_d = f_inc3(w_g2_idx);
        else if (w_g1_vld) rr_d = f_inc3(w_g1_idx);

        rd1_addr_d = rd1_addr_q;
        rd1_data_d = rd1_data_q;
        rd1_wen_d  = 1'b0;
        if (w_g1_vld) begin
            rd1_addr_d = w_addr[w_g1_idx];
            rd1_data_d = w_data[w_g1_idx];
            rd1_wen_d  = (w_addr[w_g1_idx] != 5'd0);
        end
        rd2_addr_d = rd2_addr_q;
        rd2_data_d = rd2_data_q;
        rd2_wen_d  = 1'b0;
        if (w_g2_vld) begin
            rd2_addr_d = w_addr[w_g2_idx];
            rd2_data_d = w_data[w_g2_idx];
            rd2_wen_d  = (w_addr[w_g2_idx] != 5'd0);
        end
    end

    logic [31:0] w_clr, w_set;

    // A same-edge set overrides a clear of the same register.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (rd1_wen_q) w_clr[rd1_addr_q] = 1'b1;
        if (rd2_wen_q) w_clr[rd2_addr_q] = 1'b1;
        if (i_issue_valid && i_issue_addr != 5'd0) w_set[i_issue_addr] = 1'b1;
        pending_d = ((pending_q & ~w_clr) | w_set) & ~32'h1;
        hazard_d  = i_issue_valid && (i_issue_addr != 5'd0) &&
                    pending_q[i_issue_addr] && !w_clr[i_issue_addr];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_q       <= 2'd0;
            rd1_addr_q <= 5'd0;
            rd1_data_q <= 64'd0;
            rd1_wen_q  <= 1'b0;
            rd2_addr_q <= 5'd0;
            rd2_data_q <= 64'd0;
            rd2_wen_q  <= 1'b0;
            pending_q  <= 32'd0;
            hazard_q   <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            rd1_addr_q <= rd1_addr_d;
            rd1_data_q <= rd1_data_d;
            rd1_wen_q  <= rd1_wen_d;
            rd2_addr_q <= rd2_addr_d;
            rd2_data_q <= rd2_data_d;
            rd2_wen_q  <= rd2_wen_d;
            pending_q  <= pending_d;
            hazard_q   <= hazard_d;
        end
    end

    assign o_src0_ready = w_ready[0];
    assign o_src1_ready = w_ready[1];
    assign o_src2_ready = w_ready[2];
    assign o_rd1_addr   = rd1_addr_q;
    assign o_rd1_wdata  = rd1_data_q;
    assign o_rd1_wen    = rd1_wen_q;
    assign o_rd2_addr   = rd2_addr_q;
    assign o_rd2_wdata  = rd2_data_q;
    assign o_rd2_wen    = rd2_wen_q;
    assign o_pending    = pending_q;
    assign o_hazard_err = hazard_q;

endmodule
`default_nettype wire

// File: tb/tb_warp_xwb.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_xwb
// Brief    : Scoreboard bench for warp_xwb arbitration, writeback and pending.
// Revision : 1.0
// ============================================================================
module tb_warp_xwb;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_src0_valid = 0, i_src1_valid = 0, i_src2_valid = 0;
    logic        o_src0_ready, o_src1_ready, o_src2_ready;
    logic [4:0]  i_src0_addr = 0, i_src1_addr = 0, i_src2_addr = 0;
    logic [63:0] i_src0_data = 0, i_src1_data = 0, i_src2_data = 0;
    logic        i_issue_valid = 0;
    logic [4:0]  i_issue_addr = 0;
    logic [4:0]  o_rd1_addr, o_rd2_addr;
    logic [63:0] o_rd1_wdata, o_rd2_wdata;
    logic        o_rd1_wen, o_rd2_wen;
    logic [31:0] o_pending;
    logic        o_hazard_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        w1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        w2;
        logic [4:0]  a2;
        logic [63:0] d2;
    } exp_t;
    exp_t q[$];
    exp_t e;

    warp_xwb dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_src0_valid(i_src0_valid), .i_src1_valid(i_src1_valid), .i_src2_valid(i_src2_valid),
        .o_src0_ready(o_src0_ready), .o_src1_ready(o_src1_ready), .o_src2_ready(o_src2_ready),
        .i_src0_addr(i_src0_addr), .i_src1_addr(i_src1_addr), .i_src2_addr(i_src2_addr),
        .i_src0_data(i_src0_data), .i_src1_data(i_src1_data), .i_src2_data(i_src2_data),
        .i_issue_valid(i_issue_valid), .i_issue_addr(i_issue_addr),
        .o_rd1_addr(o_rd1_addr), .o_rd2_addr(o_rd2_addr),
        .o_rd1_wdata(o_rd1_wdata), .o_rd2_wdata(o_rd2_wdata),
        .o_rd1_wen(o_rd1_wen), .o_rd2_wen(o_rd2_wen),
        .o_pending(o_pending), .o_hazard_err(o_hazard_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle;
        i_src0_valid = 0; i_src1_valid = 0; i_src2_valid = 0;
        i_issue_valid = 0;
    endtask

    task automatic set_src(input int s, input logic [4:0] a, input logic [63:0] d);
        case (s)
            0: begin i_src0_valid = 1; i_src0_addr = a; i_src0_data = d; end
            1: begin i_src1_valid = 1; i_src1_addr = a; i_src1_data = d; end
            default: begin i_src2_valid = 1; i_src2_addr = a; i_src2_data = d; end
        endcase
    endtask

    task automatic do_reset;
        idle();
        i_rst = 1;
        tick();
        i_rst = 0;
    endtask

    task automatic test_reset;
        i_rst = 1;
        set_src(0, 5'd3, 64'h77);
        #1;
        vectors++;
        if ({o_src2_ready, o_src1_ready, o_src0_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 000", {o_src2_ready, o_src1_ready, o_src0_ready});
        end
        tick();
        vectors++;
        if ({o_rd1_wen, o_rd2_wen, o_rd1_addr, o_rd2_addr, o_rd1_wdata, o_rd2_wdata,
             o_pending, o_hazard_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: wen=%b%b addr=%0d/%0d pending=%h hz=%b, want all zero",
                     o_rd1_wen, o_rd2_wen, o_rd1_addr, o_rd2_addr, o_pending, o_hazard_err);
        end
        idle();
        i_rst = 0;
    endtask

    task automatic test_single;
        do_reset();
        set_src(0, 5'd5, 64'h1234);
        #1;
        vectors++;
        if ({o_src2_ready, o_src1_ready, o_src0_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL single_ready: got %b want 001", {o_src2_ready, o_src1_ready, o_src0_ready});
        end
        q.push_back('{1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0});
        tick();
        idle();
        // rr is now 1: src1 should win port 1, src2 port 2
        set_src(0, 5'd1, 64'hA0); set_src(1, 5'd2, 64'hA1); set_src(2, 5'd3, 64'hA2);
        q.push_back('{1'b1, 5'd2, 64'hA1, 1'b1, 5'd3, 64'hA2});
        for (int n = 0; n < 2; n++) begin
            e = q.pop_front();
            vectors++;
            if (o_rd1_wen !== e.w1 || (e.w1 && (o_rd1_addr !== e.a1 || o_rd1_wdata !== e.d1))) begin
                miscompares++;
                $display("FAIL single_rd1: got wen=%b addr=%0d data=%h want wen=%b addr=%0d data=%h",
                         o_rd1_wen, o_rd1_addr, o_rd1_wdata, e.w1, e.a1, e.d1);
            end
            vectors++;
            if (o_rd2_wen !== e.w2 || (e.w2 && (o_rd2_addr !== e.a2 || o_rd2_wdata !== e.d2))) begin
                miscompares++;
                $display("FAIL single_rd2: got wen=%b addr=%0d data=%h want wen=%b addr=%0d data=%h",
                         o_rd2_wen, o_rd2_addr, o_rd2_wdata, e.w2, e.a2, e.d2);
            end
            if (n == 0) tick();
        end
        tick();
        idle();
    endtask

    task automatic test_round_robin;
        logic [2:0] want_rdy [2] = '{3'b011, 3'b101};
        do_reset();
        set_src(0, 5'd1, 64'hB0); set_src(1, 5'd2, 64'hB1); set_src(2, 5'd3, 64'hB2);
        q.push_back('{1'b1, 5'd1, 64'hB0, 1'b1, 5'd2, 64'hB1});
        q.push_back('{1'b1, 5'd3, 64'hB2, 1'b1, 5'd1, 64'hB0});
        for (int n = 0; n < 2; n++) begin
            #1;
            vectors++;
            if ({o_src2_ready, o_src1_ready, o_src0_ready} !== want_rdy[n]) begin
                miscompares++;
                $display("FAIL rr_ready[%0d]: got %b want %b", n,
                         {o_src2_ready, o_src1_ready, o_src0_ready}, want_rdy[n]);
            end
            tick();
            e = q.pop_front();
            vectors++;
            if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata} !==
                {e.w1, e.a1, e.d1, e.w2, e.a2, e.d2}) begin
                miscompares++;
                $display("FAIL rr_write[%0d]: got rd1=%b/%0d/%h rd2=%b/%0d/%h want rd1=%b/%0d/%h rd2=%b/%0d/%h",
                         n, o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata,
                         e.w1, e.a1, e.d1, e.w2, e.a2, e.d2);
            end
        end
        idle();
    endtask

    task automatic test_addr_conflict;
        do_reset();
        set_src(0, 5'd7, 64'hC0); set_src(1, 5'd7, 64'hC1); set_src(2, 5'd9, 64'hC2);
        #1;
        vectors++;
        if ({o_src2_ready, o_src1_ready, o_src0_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL conflict_ready: got %b want 101", {o_src2_ready, o_src1_ready, o_src0_ready});
        end
        q.push_back('{1'b1, 5'd7, 64'hC0, 1'b1, 5'd9, 64'hC2});
        tick();
        // rr back at 0: src1 ahead of src2
        i_src0_valid = 0;
        set_src(1, 5'd11, 64'hD1);
        q.push_back('{1'b1, 5'd11, 64'hD1, 1'b1, 5'd9, 64'hC2});
        for (int n = 0; n < 2; n++) begin
            e = q.pop_front();
            vectors++;
            if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata} !==
                {e.w1, e.a1, e.d1, e.w2, e.a2, e.d2}) begin
                miscompares++;
                $display("FAIL conflict_write[%0d]: got rd1=%b/%0d/%h rd2=%b/%0d/%h want rd1=%b/%0d/%h rd2=%b/%0d/%h",
                         n, o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata,
                         e.w1, e.a1, e.d1, e.w2, e.a2, e.d2);
            end
            tick();
            idle();
        end
    endtask

    task automatic test_x0;
        do_reset();
        i_issue_valid = 1; i_issue_addr = 5'd3;
        tick();
        i_issue_valid = 0;
        set_src(1, 5'd0, 64'hFF);
        #1;
        vectors++;
        if (o_src1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_ready: got %b want 1", o_src1_ready);
        end
        tick();
        idle();
        vectors++;
        if (o_rd1_wen !== 1'b0 || o_rd2_wen !== 1'b0 || o_pending !== 32'h8) begin
            miscompares++;
            $display("FAIL x0_write: got wen=%b%b pending=%h want wen=00 pending=00000008",
                     o_rd1_wen, o_rd2_wen, o_pending);
        end
    endtask

    task automatic test_scoreboard;
        logic [31:0] want_p [2] = '{32'h0, 32'h10};
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            i_issue_valid = 1; i_issue_addr = 5'd4;
            tick();
            i_issue_valid = 0;
            vectors++;
            if (o_pending !== 32'h10) begin
                miscompares++;
                $display("FAIL sb_set[%0d]: got %h want 00000010", pass, o_pending);
            end
            if (pass == 0) tick();
            set_src(2, 5'd4, 64'hABCD);
            #1;
            vectors++;
            if (o_src2_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL sb_ready[%0d]: got %b want 1", pass, o_src2_ready);
            end
            tick();
            idle();
            vectors++;
            if (o_rd1_wen !== 1'b1 || o_rd1_addr !== 5'd4 || o_pending !== 32'h10) begin
                miscompares++;
                $display("FAIL sb_wen[%0d]: got wen=%b addr=%0d pending=%h want wen=1 addr=4 pending=00000010",
                         pass, o_rd1_wen, o_rd1_addr, o_pending);
            end
            if (pass == 1) begin
                i_issue_valid = 1; i_issue_addr = 5'd4;
            end
            tick();
            idle();
            vectors++;
            if (o_pending !== want_p[pass] || o_hazard_err !== 1'b0) begin
                miscompares++;
                $display("FAIL sb_clear[%0d]: got pending=%h hz=%b want pending=%h hz=0",
                         pass, o_pending, o_hazard_err, want_p[pass]);
            end
        end
    endtask

    task automatic test_hazard_and_reset;
        logic want_hz [3] = '{1'b0, 1'b1, 1'b0};
        do_reset();
        for (int n = 0; n < 3; n++) begin
            i_issue_valid = (n < 2); i_issue_addr = 5'd6;
            tick();
            vectors++;
            if (o_hazard_err !== want_hz[n] || o_pending !== 32'h40) begin
                miscompares++;
                $display("FAIL hazard[%0d]: got hz=%b pending=%h want hz=%b pending=00000040",
                         n, o_hazard_err, o_pending, want_hz[n]);
            end
        end
        idle();
        set_src(0, 5'd8, 64'h55);
        tick();
        vectors++;
        if (o_rd1_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: got wen=%b want 1", o_rd1_wen);
        end
        #2 i_rst = 1;
        #1;
        vectors++;
        if (o_rd1_wen !== 1'b0 || o_pending !== 32'h0 || o_src0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst: got wen=%b pending=%h rdy0=%b want 0/00000000/0",
                     o_rd1_wen, o_pending, o_src0_ready);
        end
        tick();
        idle();
        i_rst = 0;
    endtask

    task automatic test_back_to_back;
        int p1t [3] = '{0, 2, 1};
        int p2t [3] = '{1, 0, 2};
        int k;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            k = c % 3;
            for (int s = 0; s < 3; s++) set_src(s, 5'(10 + s), 64'(c * 16 + s + 1));
            q.push_back('{1'b1, 5'(10 + p1t[k]), 64'(c * 16 + p1t[k] + 1),
                          1'b1, 5'(10 + p2t[k]), 64'(c * 16 + p2t[k] + 1)});
            #1;
            vectors++;
            if ({o_src2_ready, o_src1_ready, o_src0_ready} !== (3'b1 << p1t[k] | 3'b1 << p2t[k])) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: got %b want src%0d,src%0d", c,
                         {o_src2_ready, o_src1_ready, o_src0_ready}, p1t[k], p2t[k]);
            end
            tick();
            e = q.pop_front();
            vectors++;
            if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata} !==
                {e.w1, e.a1, e.d1, e.w2, e.a2, e.d2}) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: got rd1=%b/%0d/%h rd2=%b/%0d/%h want rd1=%b/%0d/%h rd2=%b/%0d/%h",
                         c, o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata,
                         e.w1, e.a1, e.d1, e.w2, e.a2, e.d2);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_addr_conflict();
        test_x0();
        test_scoreboard();
        test_hazard_and_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/warp_xwb.md
# warp_xwb

Scalar integer writeback unit: collects results from three execution sources over valid/ready handshakes, arbitrates them onto the two scalar register file write ports (rd1/rd2), and maintains the per-register pending scoreboard used by issue. Sits between the scalar execution units (arith, logic, long-latency load/mul) and the scalar register file, driving its write port signals from registers.

## Interface
Parameters: none. Source count (3), port count (2), register count (32) and data width (64) are fixed.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_src0_valid / i_src1_valid / i_src2_valid  in  1 each  result valid (src0 = arith, src1 = logic, src2 = long-latency).
- o_src0_ready / o_src1_ready / o_src2_ready  out  1 each  result accepted this cycle.
- i_src0_addr / i_src1_addr / i_src2_addr  in  5 each  destination register.
- i_src0_data / i_src1_data / i_src2_data  in  64 each  result value.
- i_issue_valid  in  1  instruction with scalar destination issued this cycle.
- i_issue_addr  in  5  destination register of the issued instruction.
- o_rd1_addr, o_rd2_addr  out  5 each  register file write addresses.
- o_rd1_wdata, o_rd2_wdata  out  64 each  register file write data.
- o_rd1_wen, o_rd2_wen  out  1 each  register file write enables.
- o_pending  out  32  bit n set: a write to xn is outstanding; bit 0 is always 0.
- o_hazard_err  out  1  one-cycle pulse: issue targeted an already-pending register.

## Operation
- Transfer on a source occurs when valid && ready in the same cycle. Ready is combinational from all valids, addrs and the round-robin pointer; ready is never asserted without valid.
- Round-robin pointer rr in {0,1,2}, reset 0. Arbitration scans sources in order rr, rr+1, rr+2 (mod 3).
- First valid source in scan order is granted to port 1. Next valid source is granted to port 2 unless its addr equals the port 1 grant's addr and that addr is nonzero; in that case it is skipped and the scan continues to the remaining source with the same rule. At most 2 grants per cycle.
- rr update: rr <= (last granted source index + 1) mod 3; unchanged if no grant.
- Granted results are registered: next cycle o_rdN_addr/o_rdN_wdata hold the granted source's addr/data, o_rdN_wen = 1 iff addr != 0. Ports with no grant drive wen = 0; addr/data hold previous values.
- Writes to x0 consume a port slot and are accepted, but never write and never touch the scoreboard.
- Scoreboard: on i_issue_valid with addr != 0, pending[addr] sets at the next edge. When o_rdN_wen = 1 at an edge, pending[o_rdN_addr] clears at that edge.
- Simultaneous set and clear of the same bit at one edge: set wins.
- i_issue_valid to a register whose pending bit is already 1 (and not being cleared at that edge): o_hazard_err pulses high next cycle; the bit stays set. Issue logic is required to stall on pending; this is an error indicator only.
- Sources with valid low are ignored; valid may drop without a transfer (no stickiness required of sources by this block).

## Timing
- Accept-to-write latency: 1 cycle (accept in cycle T, o_rdN_wen high in T+1, register file captures at end of T+1).
- Scoreboard clear visible on o_pending in the cycle after o_rdN_wen is high.
- Throughput: 2 results/cycle sustained; each source gets a grant at least every 2 cycles while valid with distinct addrs.
- Reset values: all o_src*_ready 0 (combinational, valids ignored during reset), o_rd1/2_addr 0, wdata 0, wen 0, o_pending 0, o_hazard_err 0, rr 0.
- Reset asserted mid-operation: registered writes in flight are dropped (wen forced 0 immediately), scoreboard cleared; sources are responsible for discarding their own state.

## Test plan
- Reset, then src0 valid addr 5 data 0x1234 alone -> o_src0_ready=1 that cycle; next cycle o_rd1_wen=1, addr 5, wdata 0x1234, o_rd2_wen=0; rr=1.
- All three valid, addrs 1/2/3, rr=0 -> src0, src1 granted (ports 1, 2), src2 not ready; rr=2; next cycle src2 granted to port 1 first.
- All three valid, src0 and src1 both addr 7, src2 addr 9, rr=0 -> src0 to port 1, src1 skipped, src2 to port 2; rr=0 after update.
- src1 valid addr 0 data 0xFF -> ready=1, next cycle o_rd1_wen=0, o_pending unchanged.
- Issue addr 4 at T -> o_pending[4]=1 at T+1; src2 result addr 4 accepted T+2 -> wen at T+3, pending[4]=0 at T+4; issue addr 4 again at T+3 -> pending[4] stays 1, no o_hazard_err.
- Issue addr 6 twice without writeback -> o_hazard_err pulses once; assert i_rst mid-stream with wen high -> wen drops to 0 immediately, o_pending=0.
